// File: rtl/ita_softmax_div_pool.sv
// Reciprocal divider pool for softmax normalisation: NUMER / den on NUM_DIV restoring
// dividers, accepted and returned in strict round-robin order so results stay in request order.

module ita_softmax_div_lane #(
  parameter int WIDTH      = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int NUMER      = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      den_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  pop_i,
  output logic                  idle_o,
  output logic                  done_o,
  output logic [WIDTH-1:0]      quot_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  div0_o
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int RW = WIDTH+1;
  localparam logic [WIDTH-1:0] NUMER_W = WIDTH'(NUMER);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic [WIDTH:0]        rem_q;
  logic [WIDTH-1:0]      quo_q, den_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  div0_q;
  logic [WIDTH+1:0]      rem_sh;
  logic                  rem_ge;
  logic [WIDTH:0]        rem_nx;

  // quo_q starts as the dividend and shifts quotient bits in from the right, MSB first
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    rem_ge = rem_sh >= {2'b00, den_q};
    rem_nx = rem_ge ? RW'(rem_sh - {2'b00, den_q}) : rem_sh[WIDTH:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BUSY;
      BUSY:    if (cnt_q == CW'(WIDTH-1)) state_d = DONE;
      DONE:    if (pop_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      addr_q <= '0;
      div0_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      den_q  <= den_i;
      addr_q <= addr_i;
      div0_q <= (den_i == '0);
      quo_q  <= NUMER_W;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == BUSY) begin
      rem_q <= rem_nx;
      quo_q <= {quo_q[WIDTH-2:0], rem_ge};
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign idle_o = (state_q == IDLE);
  assign done_o = (state_q == DONE);
  assign quot_o = div0_q ? '1 : quo_q;
  assign addr_o = addr_q;
  assign div0_o = div0_q;
endmodule

module ita_softmax_div_pool #(
  parameter int NUM_DIV    = 4,
  parameter int WIDTH      = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int NUMER      = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [WIDTH-1:0]      in_den_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_quot_o,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic                  out_div0_o,
  output logic                  busy_o
);
  localparam int PW = (NUM_DIV > 1) ? $clog2(NUM_DIV) : 1;

  logic [PW-1:0]                        wr_ptr, rd_ptr;
  logic [NUM_DIV-1:0]                   lane_idle, lane_done, lane_start, lane_pop;
  logic [NUM_DIV-1:0][WIDTH-1:0]        lane_quot;
  logic [NUM_DIV-1:0][ADDR_WIDTH-1:0]   lane_addr;
  logic [NUM_DIV-1:0]                   lane_div0;
  logic                                 accept, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_DIV-1)) ? '0 : p + PW'(1);
  endfunction

  // ready/valid look only at the pointed-to lane, from registered state: no bypass
  assign in_ready_o  = lane_idle[wr_ptr] & ~rst_i;
  assign out_valid_o = lane_done[rd_ptr];
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;
  assign busy_o      = ~(&lane_idle);
  assign out_quot_o  = out_valid_o ? lane_quot[rd_ptr] : '0;
  assign out_addr_o  = out_valid_o ? lane_addr[rd_ptr] : '0;
  assign out_div0_o  = out_valid_o & lane_div0[rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  for (genvar i = 0; i < NUM_DIV; i++) begin : g_lane
    assign lane_start[i] = accept & (wr_ptr == PW'(i));
    assign lane_pop[i]   = pop & (rd_ptr == PW'(i));
    ita_softmax_div_lane #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .NUMER(NUMER)) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (flush_i),
      .start_i (lane_start[i]),
      .den_i   (in_den_i),
      .addr_i  (in_addr_i),
      .pop_i   (lane_pop[i]),
      .idle_o  (lane_idle[i]),
      .done_o  (lane_done[i]),
      .quot_o  (lane_quot[i]),
      .addr_o  (lane_addr[i]),
      .div0_o  (lane_div0[i])
    );
  end
endmodule

// File: tb/tb_ita_softmax_div_pool.sv
// Directed + short random bench for ita_softmax_div_pool; a scoreboard checks every returned quotient.

module tb_ita_softmax_div_pool;
  logic        clk = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
  logic        in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [23:0] in_den_i = '0;
  logic [5:0]  in_addr_i = '0;
  logic        in_ready_o, out_valid_o, out_div0_o, busy_o;
  logic [23:0] out_quot_o;
  logic [5:0]  out_addr_o;

  ita_softmax_div_pool dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_den_i(in_den_i), .in_addr_i(in_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_quot_o(out_quot_o),
    .out_addr_o(out_addr_o), .out_div0_o(out_div0_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [23:0] q; logic [5:0] a; logic d; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   ret_cyc[$];
  int   ret_addr[$];
  int   cyc = 0;
  int   n_checks = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_quot(input logic [23:0] d);
    return (d == 24'd0) ? 24'hFFFFFF : 24'(32'd65536 / {8'd0, d});
  endfunction

  // scoreboard: every output handshake must match the oldest accepted request
  always @(negedge clk) begin
    #2;
    if (!rst_i && !flush_i && out_valid_o && out_ready_i) begin
      ret_cyc.push_back(cyc);
      ret_addr.push_back(int'(out_addr_o));
      if (exp_q.size() == 0) check("unexpected_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("sb_quot", out_quot_o, mon_e.q);
        check("sb_tag", out_addr_o, mon_e.a);
        check("sb_div0", out_div0_o, mon_e.d);
      end
    end
  end

  // called at a negedge; leaves in_valid_i high, returns at the negedge after the accept
  task automatic drive_req(input logic [23:0] den, input logic [5:0] addr, output int acc);
    in_valid_i = 1'b1; in_den_i = den; in_addr_i = addr; acc = -1;
    for (int n = 0; n < 300 && acc < 0; n++) begin
      #1;
      if (in_ready_o) begin
        acc = cyc;
        exp_q.push_back('{q: ref_quot(den), a: addr, d: (den == 24'd0)});
      end
      @(negedge clk);
    end
    if (acc < 0) check("req_timeout", 0, 1);
  endtask

  task automatic single(input logic [23:0] den, input logic [5:0] addr,
                        input logic [23:0] equot, input logic ediv0);
    int acc;
    drive_req(den, addr, acc);
    in_valid_i = 1'b0;
    while (!out_valid_o && cyc - acc < 60) @(negedge clk);
    check("latency", cyc - acc, 25);
    check("s_quot", out_quot_o, equot);
    check("s_addr", out_addr_o, addr);
    check("s_div0", out_div0_o, ediv0);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && (exp_q.size() != 0 || busy_o); n++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    int acc[6];
    int cnt;
    logic [23:0] sq; logic [5:0] sa; logic sd;
    logic [5:0] tag;

    // reset
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_quot", out_quot_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready_o, 1);

    // single requests: value and fixed latency
    single(24'd256,   6'd5,  24'd256,     1'b0);
    single(24'd0,     6'd6,  24'hFFFFFF,  1'b1);
    single(24'd65537, 6'd7,  24'd0,       1'b0);
    single(24'd1,     6'd8,  24'd65536,   1'b0);
    single(24'd65536, 6'd9,  24'd1,       1'b0);
    single(24'd3,     6'd10, 24'd21845,   1'b0);
    single(24'hFFFFFF,6'd11, 24'd0,       1'b0);
    single(24'd7,     6'd12, 24'd9362,    1'b0);
    wait_drain();

    // 6 back-to-back requests: 4 on consecutive cycles, 5th only after lane 0 returns
    ret_cyc.delete(); ret_addr.delete();
    for (int k = 0; k < 6; k++) drive_req(24'(k * 37 + 2), 6'(k), acc[k]);
    in_valid_i = 1'b0;
    wait_drain();
    check("b2b_acc1", acc[1] - acc[0], 1);
    check("b2b_acc3", acc[3] - acc[0], 3);
    check("b2b_n_ret", ret_addr.size(), 6);
    if (ret_addr.size() == 6) begin
      check("b2b_5th_after_ret0", acc[4] > ret_cyc[0], 1);
      for (int k = 0; k < 6; k++) check("b2b_order", ret_addr[k], k);
    end

    // output stall: 4 requests held, full pool, stable outputs
    out_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) drive_req(24'(k + 100), 6'(20 + k), acc[k]);
    in_valid_i = 1'b0;
    #1 check("full_ready", in_ready_o, 0);
    for (int n = 0; n < 60 && !out_valid_o; n++) @(negedge clk);
    check("stall_valid", out_valid_o, 1);
    sq = out_quot_o; sa = out_addr_o; sd = out_div0_o;
    check("stall_first_tag", sa, 20);
    cnt = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (!out_valid_o || in_ready_o || out_quot_o !== sq || out_addr_o !== sa || out_div0_o !== sd) cnt++;
    end
    check("stall_hold", cnt, 0);
    ret_cyc.delete();
    out_ready_i = 1'b1;
    wait_drain();
    check("release_n", ret_cyc.size(), 4);
    if (ret_cyc.size() == 4) check("release_rate", ret_cyc[3] - ret_cyc[0], 3);

    // flush with 3 busy lanes; request in the flush cycle is dropped
    for (int k = 0; k < 3; k++) drive_req(24'(k + 5), 6'(30 + k), acc[k]);
    in_valid_i = 1'b0;
    repeat (5) @(negedge clk);
    flush_i = 1'b1; in_valid_i = 1'b1; in_den_i = 24'd9; in_addr_i = 6'd40;
    exp_q.delete();
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    check("flush_busy", busy_o, 0);
    check("flush_ready", in_ready_o, 1);
    cnt = 0;
    repeat (30) begin @(negedge clk); #1; if (out_valid_o) cnt++; end
    check("flush_no_valid", cnt, 0);

    // async reset between edges: one lane DONE and held, one mid-division
    out_ready_i = 1'b0;
    drive_req(24'd7, 6'd1, acc[0]);
    in_valid_i = 1'b0;
    repeat (15) @(negedge clk);
    drive_req(24'd100, 6'd2, acc[1]);
    in_valid_i = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_rst_valid", out_valid_o, 1);
    @(posedge clk); #2;
    rst_i = 1'b1;
    #1;
    check("arst_valid", out_valid_o, 0);
    check("arst_quot", out_quot_o, 0);
    check("arst_addr", out_addr_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_ready", in_ready_o, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    single(24'd3, 6'd9, 24'd21845, 1'b0);
    wait_drain();

    // random regression: random dens and output stalls, scoreboard checks order and values
    tag = 6'd0;
    ret_addr.delete();
    cnt = 0;
    repeat (600) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      in_valid_i  = ($urandom_range(0, 1) != 0);
      case ($urandom_range(0, 5))
        0: in_den_i = 24'd0;
        1: in_den_i = 24'd1;
        2: in_den_i = 24'($urandom_range(1, 300));
        3: in_den_i = 24'd65537;
        4: in_den_i = 24'd65536;
        default: in_den_i = 24'($urandom);
      endcase
      in_addr_i = tag;
      #1;
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back('{q: ref_quot(in_den_i), a: tag, d: (in_den_i == 24'd0)});
        tag = tag + 6'd1;
        cnt++;
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    wait_drain();
    check("rand_count", ret_addr.size(), cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
